// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bundle: combinational ROM port, IF/ID valid/ready slot,
// downstream redirect request and halt status.
interface inst_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  romChipEnable;
  logic [ADDR_WIDTH-1:0] romAddr;
  logic [DATA_WIDTH-1:0] romInst;
  logic                  outValid;
  logic                  outReady;
  logic [ADDR_WIDTH-1:0] outPc;
  logic [DATA_WIDTH-1:0] outInst;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirectTarget;
  logic                  halted;

  // The fetch unit drives the ROM request, the slot and the halt flag.
  modport master (
    output romChipEnable, romAddr, outValid, outPc, outInst, halted,
    input  romInst, outReady, redirect, redirectTarget
  );

  // ROM / decode / branch-resolution side.
  modport slave (
    input  romChipEnable, romAddr, outValid, outPc, outInst, halted,
    output romInst, outReady, redirect, redirectTarget
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per cycle from a
// combinational ROM into a single registered output slot, honours decode
// back-pressure, restarts on redirect and halts on an illegal PC.
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    ROM_WORDS  = 10
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-3:0] ROM_WORDS_W = (ADDR_WIDTH-2)'(ROM_WORDS);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] out_pc_reg, out_pc_next;
  logic [DATA_WIDTH-1:0] out_inst_reg, out_inst_next;
  logic                  out_valid_reg, out_valid_next;
  logic                  halted_reg, halted_next;
  logic                  rom_en;

  logic transfer;
  logic slot_free;
  logic pc_legal;

  // A redirect cancels the slot in the same cycle, so it never counts as a transfer.
  assign transfer  = out_valid_reg && bus.outReady && !bus.redirect;
  assign slot_free = !out_valid_reg || transfer;
  assign pc_legal  = (pc_reg[1:0] == 2'b00) && (pc_reg[ADDR_WIDTH-1:2] < ROM_WORDS_W);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: redirect always lands in FETCH; illegal PC parks in HALTED.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH: begin
        if (bus.redirect) begin
          state_next = FETCH;
        end else if (!pc_legal) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        if (bus.redirect) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next-values: ROM enable and the PC/slot/halt updates.
  always_comb begin
    rom_en         = 1'b0;
    pc_next        = pc_reg;
    out_pc_next    = out_pc_reg;
    out_inst_next  = out_inst_reg;
    out_valid_next = transfer ? 1'b0 : out_valid_reg;
    halted_next    = halted_reg;
    if (bus.redirect) begin
      // Highest priority in every state; the slot content is dropped.
      pc_next        = bus.redirectTarget;
      out_valid_next = 1'b0;
      halted_next    = 1'b0;
    end else if (state_reg == FETCH) begin
      if (!pc_legal) begin
        halted_next = 1'b1;
      end else if (slot_free) begin
        rom_en         = 1'b1;
        out_inst_next  = bus.romInst;
        out_pc_next    = pc_reg;
        out_valid_next = 1'b1;
        pc_next        = pc_reg + ADDR_WIDTH'(4);
      end
    end
  end

  // Datapath registers; reset clears the slot immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg        <= RESET_PC;
      out_pc_reg    <= '0;
      out_inst_reg  <= '0;
      out_valid_reg <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      out_pc_reg    <= out_pc_next;
      out_inst_reg  <= out_inst_next;
      out_valid_reg <= out_valid_next;
      halted_reg    <= halted_next;
    end
  end

  assign bus.romChipEnable = rom_en;
  assign bus.romAddr       = pc_reg;
  assign bus.outValid      = out_valid_reg;
  assign bus.outPc         = out_pc_reg;
  assign bus.outInst       = out_inst_reg;
  assign bus.halted        = halted_reg;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed timing checks plus randomized
// back-pressure/redirect traffic, with a scoreboard of expected transfers.
module tb_inst_fetch_unit;
  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          NW       = 10;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  inst_fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC(RESET_PC),
    .ROM_WORDS(NW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic bit legal(logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < NW);
  endfunction

  function automatic logic [31:0] rom_word(logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // ROM model: combinational read.
  always_comb bus.romInst = legal(bus.romAddr) ? rom_word(bus.romAddr) : 32'hBAD0_0000;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: after a (re)start at 'start', decode receives every legal
  // word-aligned PC upward from it, in order, and then nothing more.
  function automatic void load_seq(logic [31:0] start);
    exp_q.delete();
    for (logic [31:0] a = start; legal(a); a += 4) begin
      exp_q.push_back({a, rom_word(a)});
    end
  endfunction

  // Monitor: mid-cycle sampling of transfers and ROM requests.
  always @(negedge clk) begin
    item_t e;
    if (rst_n) begin
      if (bus.romChipEnable) begin
        check("rom_en_addr_legal", 32'(legal(bus.romAddr)), 32'd1);
      end
      if (bus.outValid && bus.outReady && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_transfer: got pc %h, required no transfer", bus.outPc);
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc", bus.outPc, e.pc);
          check("xfer_inst", bus.outInst, e.inst);
          $display("xfer pc=%h inst=%h", bus.outPc, bus.outInst);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    #1;
    check("rst_outValid", 32'(bus.outValid), 32'd0);
    check("rst_outPc", bus.outPc, 32'd0);
    check("rst_outInst", bus.outInst, 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_romChipEnable", 32'(bus.romChipEnable), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    load_seq(RESET_PC);
  endtask

  task automatic wait_halt();
    bus.outReady = 1'b1;
    bus.redirect = 1'b0;
    for (int c = 0; c < 60 && !(bus.halted && !bus.outValid); c++) tick();
    check("halt_reached", 32'(bus.halted && !bus.outValid), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    bus.outReady       = 1'b1;
    bus.redirect       = 1'b0;
    bus.redirectTarget = '0;

    // Straight-line stream with outReady held high.
    do_reset();
    tick();
    check("idle_exit_valid", 32'(bus.outValid), 32'd0);
    check("first_fetch_en", 32'(bus.romChipEnable), 32'd1);
    check("first_fetch_addr", bus.romAddr, RESET_PC);
    for (int i = 0; i < NW; i++) begin
      tick();
      check("stream_valid", 32'(bus.outValid), 32'd1);
      check("stream_pc", bus.outPc, 32'(4 * i));
    end
    tick();
    check("end_halted", 32'(bus.halted), 32'd1);
    check("end_valid", 32'(bus.outValid), 32'd0);
    check("end_queue", 32'(exp_q.size()), 32'd0);

    // Back-pressure while slot holds pc=8.
    do_reset();
    tick();
    tick();
    tick();
    tick();
    check("bp_slot_pc", bus.outPc, 32'h8);
    bus.outReady = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 32'(bus.outValid), 32'd1);
      check("bp_pc", bus.outPc, 32'h8);
      check("bp_inst", bus.outInst, 32'h1000_0002);
      check("bp_rom_en", 32'(bus.romChipEnable), 32'd0);
      check("bp_rom_addr", bus.romAddr, 32'hC);
      tick();
    end
    bus.outReady = 1'b1;
    #1;
    check("bp_resume_en", 32'(bus.romChipEnable), 32'd1);
    check("bp_resume_addr", bus.romAddr, 32'hC);
    tick();
    check("bp_next_valid", 32'(bus.outValid), 32'd1);
    check("bp_next_pc", bus.outPc, 32'hC);
    wait_halt();

    // Redirect while slot holds pc=8 and outReady=1.
    do_reset();
    tick();
    tick();
    tick();
    tick();
    check("rd_slot_pc", bus.outPc, 32'h8);
    bus.redirect       = 1'b1;
    bus.redirectTarget = 32'h14;
    load_seq(32'h14);
    #1;
    check("rd_rom_en", 32'(bus.romChipEnable), 32'd0);
    tick();
    bus.redirect = 1'b0;
    #1;
    check("rd_bubble_valid", 32'(bus.outValid), 32'd0);
    check("rd_fetch_en", 32'(bus.romChipEnable), 32'd1);
    check("rd_fetch_addr", bus.romAddr, 32'h14);
    tick();
    check("rd_tgt_valid", 32'(bus.outValid), 32'd1);
    check("rd_tgt_pc", bus.outPc, 32'h14);
    check("rd_tgt_inst", bus.outInst, 32'h1000_0005);
    wait_halt();

    // Leave HALTED via redirect, then re-halt on a misaligned target.
    bus.redirect       = 1'b1;
    bus.redirectTarget = 32'h4;
    load_seq(32'h4);
    tick();
    bus.redirect = 1'b0;
    check("hr_halted_clear", 32'(bus.halted), 32'd0);
    check("hr_bubble", 32'(bus.outValid), 32'd0);
    tick();
    check("hr_valid", 32'(bus.outValid), 32'd1);
    check("hr_pc", bus.outPc, 32'h4);
    check("hr_inst", bus.outInst, 32'h1000_0001);
    bus.redirect       = 1'b1;
    bus.redirectTarget = 32'h6;
    load_seq(32'h6);
    #1;
    check("mis_rom_en0", 32'(bus.romChipEnable), 32'd0);
    tick();
    bus.redirect = 1'b0;
    #1;
    check("mis_rom_en1", 32'(bus.romChipEnable), 32'd0);
    check("mis_valid", 32'(bus.outValid), 32'd0);
    tick();
    check("mis_halted", 32'(bus.halted), 32'd1);

    // Restart, stream a little, then async reset mid-stream.
    bus.redirect       = 1'b1;
    bus.redirectTarget = 32'h0;
    load_seq(32'h0);
    tick();
    bus.redirect = 1'b0;
    tick();
    tick();
    tick();
    do_reset();
    tick();
    tick();
    check("rst2_valid", 32'(bus.outValid), 32'd1);
    check("rst2_pc", bus.outPc, RESET_PC);

    // Randomized back-pressure and redirects.
    for (int n = 0; n < 600; n++) begin
      tick();
      bus.outReady = ($urandom_range(0, 3) != 0);
      if (!bus.redirect && $urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0:       tgt = 32'($urandom_range(0, 63));
          1:       tgt = 32'(4 * $urandom_range(10, 14));
          default: tgt = 32'(4 * $urandom_range(0, NW - 1));
        endcase
        bus.redirect       = 1'b1;
        bus.redirectTarget = tgt;
        load_seq(tgt);
      end else begin
        bus.redirect = 1'b0;
      end
    end
    tick();
    wait_halt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
